net_tx_arbiter: RTL and testbench

NET_TX_ARBITER -- requirements
Module: net_tx_arbiter

---
 rtl/net_tx_arbiter.sv | 274 +++++++++++++++++++++++++++
 tb/tb_net_tx_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/net_tx_arbiter.sv
// net_tx_arbiter: merges ARP, ICMP and UDP byte streams into a single
// MAC TX stream. Whole frames are granted round-robin and never interleaved.
// Optional feature: define ARB_TIMEOUT_EN to abort a frame whose granted
// source stalls for TIMEOUT_CYCLES cycles. The abort emits a single
// tlast beat with data 8'h00.
module net_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic       logic_clk,
    input  logic       logic_rst,

    input  logic [7:0] arp_tdata_in,
    input  logic       arp_tvalid_in,
    input  logic       arp_tlast_in,
    output logic       arp_tready_out,

    input  logic [7:0] icmp_tdata_in,
    input  logic       icmp_tvalid_in,
    input  logic       icmp_tlast_in,
    output logic       icmp_tready_out,

    input  logic [7:0] udp_tdata_in,
    input  logic       udp_tvalid_in,
    input  logic       udp_tlast_in,
    output logic       udp_tready_out,

    output logic [7:0] net_tdata_out,
    output logic       net_tvalid_out,
    output logic       net_tlast_out,
    input  logic       net_tready_in,

    output logic [2:0] arb_grant_out,
    output logic       arb_timeout_out
);

`ifdef ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, ABORT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;
`endif

    // The stall counter must be able to reach TIMEOUT_CYCLES. This block
    // marks an out-of-range configuration in the elaborated hierarchy.
    if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_cfg_counter_too_narrow
    end

    // Source index order is arp=0, icmp=1, udp=2.
    function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    state_t      state_reg, state_next;
    logic [2:0]  grant_reg, grant_next;
    logic [1:0]  ptr_reg, ptr_next;
    // arm_reg holds off arbitration for one edge after reset release so
    // the first grant lands no earlier than the second rising edge.
    logic        arm_reg;

    logic [7:0]  src_data  [3];
    logic [2:0]  src_valid;
    logic [2:0]  src_last;
    logic [2:0]  src_ready;

    logic [1:0]  cand_idx  [3];
    logic [2:0]  cand_valid;
    logic        pick_valid;
    logic [1:0]  pick_idx;
    logic [1:0]  grant_idx;

    logic [7:0]  mux_data;
    logic        mux_valid;
    logic        mux_last;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        net_fire;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             timeout_reg, timeout_next;
`endif

    // Gather the three requester ports into indexable form.
    assign src_data[0]  = arp_tdata_in;
    assign src_data[1]  = icmp_tdata_in;
    assign src_data[2]  = udp_tdata_in;
    assign src_valid    = {udp_tvalid_in, icmp_tvalid_in, arp_tvalid_in};
    assign src_last     = {udp_tlast_in, icmp_tlast_in, arp_tlast_in};

    assign arp_tready_out  = src_ready[0];
    assign icmp_tready_out = src_ready[1];
    assign udp_tready_out  = src_ready[2];

    // Candidate gi is the source gi positions after the round-robin pointer.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cand
            assign cand_idx[gi]   = add_mod3(ptr_reg, 2'(gi));
            assign cand_valid[gi] = src_valid[cand_idx[gi]];
        end
    endgenerate

    // Round-robin selection: first valid candidate starting at the pointer.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        if (cand_valid[0]) begin
            pick_valid = 1'b1;
            pick_idx   = cand_idx[0];
        end else if (cand_valid[1]) begin
            pick_valid = 1'b1;
            pick_idx   = cand_idx[1];
        end else if (cand_valid[2]) begin
            pick_valid = 1'b1;
            pick_idx   = cand_idx[2];
        end
    end

    // Encode the one-hot grant back to a source index.
    always_comb begin
        grant_idx = 2'd0;
        if (grant_reg[1]) begin
            grant_idx = 2'd1;
        end else if (grant_reg[2]) begin
            grant_idx = 2'd2;
        end
    end

    // Data-path mux of the granted source.
    always_comb begin
        mux_data  = 8'h00;
        mux_valid = 1'b0;
        mux_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (grant_reg[i]) begin
                mux_data  = mux_data | src_data[i];
                mux_valid = mux_valid | src_valid[i];
                mux_last  = mux_last | src_last[i];
            end
        end
    end

    // Ready is only ever returned to the granted source while in GRANT.
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ready
            assign src_ready[gi] = (state_reg == GRANT) & grant_reg[gi] & net_tready_in;
        end
    endgenerate

    // Merged output stream: the granted source, the abort beat, or all zero.
    always_comb begin
        out_data  = 8'h00;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state_reg)
            GRANT: begin
                out_data  = mux_data;
                out_valid = mux_valid;
                out_last  = mux_last;
            end
`ifdef ARB_TIMEOUT_EN
            ABORT: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
            end
`endif
            default: begin
                out_data  = 8'h00;
                out_valid = 1'b0;
                out_last  = 1'b0;
            end
        endcase
    end

    assign net_tdata_out  = out_data;
    assign net_tvalid_out = out_valid;
    assign net_tlast_out  = out_last;
    assign net_fire       = out_valid & net_tready_in;
    assign arb_grant_out  = grant_reg;

`ifdef ARB_TIMEOUT_EN
    assign arb_timeout_out = timeout_reg;
`else
    assign arb_timeout_out = 1'b0;
`endif

    // Next-state logic: arbitrate in IDLE, release at frame end or abort.
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        ptr_next   = ptr_reg;
`ifdef ARB_TIMEOUT_EN
        cnt_next     = cnt_reg;
        timeout_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
`ifdef ARB_TIMEOUT_EN
                cnt_next = '0;
`endif
                if (arm_reg && pick_valid) begin
                    grant_next = 3'b001 << pick_idx;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (net_fire && out_last) begin
                    state_next = IDLE;
                    grant_next = 3'b000;
                    ptr_next   = add_mod3(grant_idx, 2'd1);
                end
`ifdef ARB_TIMEOUT_EN
                else if (mux_valid) begin
                    cnt_next = '0;
                end else if (cnt_reg + CNT_W'(1) == CNT_W'(TIMEOUT_CYCLES)) begin
                    cnt_next   = '0;
                    state_next = ABORT;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
`endif
            end
`ifdef ARB_TIMEOUT_EN
            ABORT: begin
                if (net_tready_in) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                    grant_next   = 3'b000;
                    ptr_next     = add_mod3(grant_idx, 2'd1);
                end
            end
`endif
            default: begin
                state_next = IDLE;
                grant_next = 3'b000;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge logic_clk or posedge logic_rst) begin
        if (logic_rst) begin
            state_reg <= IDLE;
            grant_reg <= 3'b000;
            ptr_reg   <= 2'd0;
            arm_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            ptr_reg   <= ptr_next;
            arm_reg   <= 1'b1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Stall counter and registered abort pulse.
    always_ff @(posedge logic_clk or posedge logic_rst) begin
        if (logic_rst) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end
`endif

endmodule

// File: tb/tb_net_tx_arbiter.sv
// Scoreboard testbench for net_tx_arbiter. Expected beats are queued when
// frames are scheduled and compared as the merged stream transfers them.
module tb_net_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] arp_tdata_in, icmp_tdata_in, udp_tdata_in;
    logic       arp_tvalid_in, icmp_tvalid_in, udp_tvalid_in;
    logic       arp_tlast_in, icmp_tlast_in, udp_tlast_in;
    logic       arp_tready_out, icmp_tready_out, udp_tready_out;
    logic [7:0] net_tdata_out;
    logic       net_tvalid_out, net_tlast_out;
    logic       net_tready_in;
    logic [2:0] arb_grant_out;
    logic       arb_timeout_out;

    always #5 clk = ~clk;

    net_tx_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
        .logic_clk(clk),
        .logic_rst(rst),
        .arp_tdata_in(arp_tdata_in),
        .arp_tvalid_in(arp_tvalid_in),
        .arp_tlast_in(arp_tlast_in),
        .arp_tready_out(arp_tready_out),
        .icmp_tdata_in(icmp_tdata_in),
        .icmp_tvalid_in(icmp_tvalid_in),
        .icmp_tlast_in(icmp_tlast_in),
        .icmp_tready_out(icmp_tready_out),
        .udp_tdata_in(udp_tdata_in),
        .udp_tvalid_in(udp_tvalid_in),
        .udp_tlast_in(udp_tlast_in),
        .udp_tready_out(udp_tready_out),
        .net_tdata_out(net_tdata_out),
        .net_tvalid_out(net_tvalid_out),
        .net_tlast_out(net_tlast_out),
        .net_tready_in(net_tready_in),
        .arb_grant_out(arb_grant_out),
        .arb_timeout_out(arb_timeout_out)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [2:0] grant;
    } beat_t;

    beat_t      exp_q [$];
    logic [8:0] src_q [3][$];
    bit         src_en [3];
    int         src_left [3];

    int checks = 0;
    int errors = 0;
    bit ready_toggle = 1'b0;
    bit chk_ready = 1'b1;
    bit gap_chk = 1'b0;
    bit seen_last = 1'b0;
    int gap_cnt = 0;
    int pulses = 0;
    int stall_cnt = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] onehot(input int s);
        logic [2:0] g;
        g    = 3'b000;
        g[s] = 1'b1;
        return g;
    endfunction

    task automatic queue_frame(input int s, input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            src_q[s].push_back({(i == len - 1), base + 8'(i)});
        end
    endtask

    task automatic expect_frame(input int s, input int first, input int len, input logic [7:0] base);
        beat_t b;
        for (int i = first; i < len; i++) begin
            b.data  = base + 8'(i);
            b.last  = (i == len - 1);
            b.grant = onehot(s);
            exp_q.push_back(b);
        end
    endtask

    task automatic drive_inputs();
        logic [7:0] d [3];
        logic       v [3];
        logic       l [3];
        for (int s = 0; s < 3; s++) begin
            v[s] = src_en[s] && (src_q[s].size() > 0);
            d[s] = (src_q[s].size() > 0) ? src_q[s][0][7:0] : 8'h00;
            l[s] = (src_q[s].size() > 0) ? src_q[s][0][8] : 1'b0;
        end
        arp_tdata_in  = d[0]; arp_tvalid_in  = v[0]; arp_tlast_in  = l[0];
        icmp_tdata_in = d[1]; icmp_tvalid_in = v[1]; icmp_tlast_in = l[1];
        udp_tdata_in  = d[2]; udp_tvalid_in  = v[2]; udp_tlast_in  = l[2];
    endtask

    // Sampled on the falling edge, when everything is settled.
    task automatic monitor();
        logic [2:0] g;
        logic [2:0] rdy;
        beat_t      e;
        g   = arb_grant_out;
        rdy = {udp_tready_out, icmp_tready_out, arp_tready_out};
        if (g == 3'b000) begin
            gap_cnt++;
        end else begin
            if (gap_chk && seen_last) begin
                check_value("idle_gap", gap_cnt, 1);
                seen_last = 1'b0;
            end
            gap_cnt = 0;
        end
        if (net_tvalid_out && net_tready_in) begin
            if (exp_q.size() == 0) begin
                check_value("unexpected_beat", {net_tlast_out, net_tdata_out}, 0);
            end else begin
                e = exp_q.pop_front();
                check_value("beat_data", net_tdata_out, e.data);
                check_value("beat_last", net_tlast_out, e.last);
                check_value("beat_grant", g, e.grant);
                $display("beat data=%02h last=%0b grant=%03b", net_tdata_out, net_tlast_out, g);
            end
            if (net_tlast_out) seen_last = 1'b1;
        end
        if (chk_ready) begin
            for (int s = 0; s < 3; s++) begin
                check_value("ready_gating", rdy[s], g[s] & net_tready_in);
            end
        end
        if (arb_timeout_out) pulses++;
        if (g == 3'b100 && !net_tvalid_out) stall_cnt++;
    endtask

    task automatic tick();
        bit fire [3];
        @(negedge clk);
        monitor();
        fire[0] = arp_tvalid_in && arp_tready_out;
        fire[1] = icmp_tvalid_in && icmp_tready_out;
        fire[2] = udp_tvalid_in && udp_tready_out;
        @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            if (fire[s]) begin
                void'(src_q[s].pop_front());
                if (src_left[s] > 0) begin
                    src_left[s]--;
                    if (src_left[s] == 0) src_en[s] = 1'b0;
                end
            end
        end
        net_tready_in = ready_toggle ? ~net_tready_in : 1'b1;
        drive_inputs();
    endtask

    function automatic bit busy();
        bit b;
        b = (exp_q.size() != 0);
        for (int s = 0; s < 3; s++) begin
            if (src_en[s] && src_q[s].size() != 0) b = 1'b1;
        end
        return b;
    endfunction

    task automatic run_until_done(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (busy() && n < max_cycles) begin
            tick();
            n++;
        end
        check_value({tag, "_done"}, (n < max_cycles), 1);
        tick();
        tick();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        net_tready_in = 1'b1;
        for (int s = 0; s < 3; s++) begin
            src_en[s]   = 1'b1;
            src_left[s] = -1;
        end
        drive_inputs();
        #1;
        check_value("rst_grant", arb_grant_out, 0);
        check_value("rst_tvalid", net_tvalid_out, 0);
        check_value("rst_tdata", net_tdata_out, 0);
        check_value("rst_timeout", arb_timeout_out, 0);
        check_value("rst_ready", {udp_tready_out, icmp_tready_out, arp_tready_out}, 0);

        // Three simultaneous 10-byte frames right after reset release.
        queue_frame(0, 10, 8'h10); queue_frame(1, 10, 8'h40); queue_frame(2, 10, 8'h70);
        expect_frame(0, 0, 10, 8'h10); expect_frame(1, 0, 10, 8'h40); expect_frame(2, 0, 10, 8'h70);
        drive_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check_value("first_grant_delay", arb_grant_out, 3'b000);
        tick();
        check_value("first_grant_arp", arb_grant_out, 3'b001);
        gap_chk = 1'b1;
        seen_last = 1'b0;
        run_until_done("rr_three", 200);
        gap_chk = 1'b0;

        // Single 42-byte ARP frame.
        queue_frame(0, 42, 8'h80);
        expect_frame(0, 0, 42, 8'h80);
        run_until_done("arp42", 200);
        check_value("grant_after_frame", arb_grant_out, 0);

        // 64-byte UDP frame with ARP requesting during beat 5.
        queue_frame(2, 64, 8'h00);
        expect_frame(2, 0, 64, 8'h00);
        n = 0;
        while (src_q[2].size() > 60 && n < 100) begin
            tick();
            n++;
        end
        queue_frame(0, 8, 8'hc0);
        expect_frame(0, 0, 8, 8'hc0);
        drive_inputs();
        tick();
        check_value("arp_held_off", arp_tready_out, 0);
        run_until_done("udp_midreq", 300);

        // 20-byte ICMP frame with net_tready toggling every cycle.
        ready_toggle = 1'b1;
        queue_frame(1, 20, 8'h20);
        expect_frame(1, 0, 20, 8'h20);
        run_until_done("icmp_toggle", 200);
        ready_toggle = 1'b0;
        net_tready_in = 1'b1;

        // Short ARP frame so the pointer sits on icmp before the reset test.
        queue_frame(0, 4, 8'hd0);
        expect_frame(0, 0, 4, 8'hd0);
        run_until_done("arp4", 50);

        // Reset during beat 7 of a 30-byte ARP frame.
        queue_frame(0, 30, 8'h30);
        expect_frame(0, 0, 30, 8'h30);
        drive_inputs();
        n = 0;
        while (src_q[0].size() > 24 && n < 100) begin
            tick();
            n++;
        end
        #2;
        rst = 1'b1;
        #1;
        check_value("midrst_tvalid", net_tvalid_out, 0);
        check_value("midrst_tlast", net_tlast_out, 0);
        check_value("midrst_tdata", net_tdata_out, 0);
        check_value("midrst_grant", arb_grant_out, 0);
        check_value("midrst_ready", arp_tready_out, 0);
        check_value("midrst_timeout", arb_timeout_out, 0);
        exp_q.delete();
        for (int s = 0; s < 3; s++) src_q[s].delete();
        drive_inputs();
        @(posedge clk);
        #1;
        queue_frame(1, 6, 8'h50); queue_frame(0, 6, 8'h60);
        expect_frame(0, 0, 6, 8'h60); expect_frame(1, 0, 6, 8'h50);
        drive_inputs();
        rst = 1'b0;
        run_until_done("post_rst", 100);

`ifdef ARB_TIMEOUT_EN
        // UDP goes silent after 3 beats; the frame must be aborted.
        chk_ready = 1'b0;
        stall_cnt = 0;
        pulses = 0;
        queue_frame(2, 10, 8'ha0);
        src_left[2] = 3;
        expect_frame(2, 0, 3, 8'ha0);
        begin
            beat_t b;
            b.data = 8'h00; b.last = 1'b1; b.grant = 3'b100;
            exp_q.push_back(b);
        end
        drive_inputs();
        tick();
        tick();
        queue_frame(1, 5, 8'he0);
        expect_frame(1, 0, 5, 8'he0);
        drive_inputs();
        n = 0;
        while (pulses == 0 && n < 100) begin
            tick();
            n++;
        end
        check_value("abort_seen", (n < 100), 1);
        check_value("stall_cycles", stall_cnt, 16);
        chk_ready = 1'b1;
        src_en[2] = 1'b1;
        src_left[2] = -1;
        expect_frame(2, 3, 10, 8'ha0);
        drive_inputs();
        run_until_done("after_abort", 100);
        check_value("timeout_pulses", pulses, 1);
`else
        check_value("timeout_pulses", pulses, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
